// File: rtl/pll_lock_reset_ctrl.sv
// rtl/pll_lock_reset_ctrl.sv - PLL reset sequencing, lock supervision and system reset release
// Runs on refclk so it keeps sequencing while the PLL output is unusable.
module pll_lock_reset_ctrl #(
  parameter int PLL_RST_CYCLES = 16,
  parameter int LOCK_TIMEOUT   = 65535,
  parameter int STABLE_CYCLES  = 1024,
  parameter int MAX_RETRY      = 4,
  parameter int CNT_W          = 8
) (
  input  logic             refclk,
  input  logic             rst_n,
  input  logic             pll_locked,
  input  logic             soft_relock,
  output logic             pll_rst,
  output logic             sys_rst_n,
  output logic             pll_ready,
  output logic             fault,
  output logic [CNT_W-1:0] lock_lost_cnt,
  output logic [CNT_W-1:0] retry_cnt
);

  localparam int MAX_AB = (PLL_RST_CYCLES > LOCK_TIMEOUT) ? PLL_RST_CYCLES : LOCK_TIMEOUT;
  localparam int MAX_V  = (MAX_AB > STABLE_CYCLES) ? MAX_AB : STABLE_CYCLES;
  localparam int CW     = $clog2(MAX_V) + 1;
  localparam int TW     = $clog2(MAX_RETRY + 1);

  localparam logic [CW-1:0]    RST_LAST  = CW'(PLL_RST_CYCLES - 1);
  localparam logic [CW-1:0]    TMO_LAST  = CW'(LOCK_TIMEOUT - 1);
  localparam logic [CW-1:0]    STB_LAST  = CW'(STABLE_CYCLES - 1);
  localparam logic [TW-1:0]    TCNT_MAX  = TW'(MAX_RETRY);
  localparam logic [CNT_W-1:0] STAT_MAX  = {CNT_W{1'b1}};

  typedef enum logic [2:0] {
    S_RESET_PLL,
    S_WAIT_LOCK,
    S_STABILIZE,
    S_RUN,
    S_FAULT
  } state_t;

  state_t           state, state_nxt;
  logic [CW-1:0]    cnt, cnt_nxt;
  logic [TW-1:0]    tcnt, tcnt_nxt, tcnt_inc;
  logic [CNT_W-1:0] lost_nxt, retry_nxt;
  logic             pll_rst_nxt, sys_rst_n_nxt, pll_ready_nxt, fault_nxt;
  logic             sync1, lk_s;

  always_ff @(posedge refclk or negedge rst_n) begin
    if (!rst_n) begin
      sync1 <= 1'b0;
      lk_s  <= 1'b0;
    end else begin
      sync1 <= pll_locked;
      lk_s  <= sync1;
    end
  end

  always_ff @(posedge refclk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= S_RESET_PLL;
      cnt           <= '0;
      tcnt          <= '0;
      lock_lost_cnt <= '0;
      retry_cnt     <= '0;
      pll_rst       <= 1'b1;
      sys_rst_n     <= 1'b0;
      pll_ready     <= 1'b0;
      fault         <= 1'b0;
    end else begin
      state         <= state_nxt;
      cnt           <= cnt_nxt;
      tcnt          <= tcnt_nxt;
      lock_lost_cnt <= lost_nxt;
      retry_cnt     <= retry_nxt;
      pll_rst       <= pll_rst_nxt;
      sys_rst_n     <= sys_rst_n_nxt;
      pll_ready     <= pll_ready_nxt;
      fault         <= fault_nxt;
    end
  end

  assign tcnt_inc = tcnt + TW'(1);

  // soft_relock pre-empts every state, including a lock loss seen in RUN
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    tcnt_nxt  = tcnt;
    lost_nxt  = lock_lost_cnt;
    retry_nxt = retry_cnt;
    if (soft_relock) begin
      state_nxt = S_RESET_PLL;
      cnt_nxt   = '0;
      tcnt_nxt  = '0;
    end else begin
      case (state)
        S_RESET_PLL: begin
          if (cnt == RST_LAST) begin
            state_nxt = S_WAIT_LOCK;
            cnt_nxt   = '0;
          end else begin
            cnt_nxt = cnt + CW'(1);
          end
        end
        S_WAIT_LOCK: begin
          if (lk_s) begin
            state_nxt = S_STABILIZE;
            cnt_nxt   = '0;
          end else if (cnt == TMO_LAST) begin
            if (retry_cnt != STAT_MAX) retry_nxt = retry_cnt + CNT_W'(1);
            tcnt_nxt  = tcnt_inc;
            state_nxt = (tcnt_inc == TCNT_MAX) ? S_FAULT : S_RESET_PLL;
            cnt_nxt   = '0;
          end else begin
            cnt_nxt = cnt + CW'(1);
          end
        end
        S_STABILIZE: begin
          if (!lk_s) begin
            state_nxt = S_WAIT_LOCK;
            cnt_nxt   = '0;
          end else if (cnt == STB_LAST) begin
            state_nxt = S_RUN;
            tcnt_nxt  = '0;
          end else begin
            cnt_nxt = cnt + CW'(1);
          end
        end
        S_RUN: begin
          if (!lk_s) begin
            if (lock_lost_cnt != STAT_MAX) lost_nxt = lock_lost_cnt + CNT_W'(1);
            state_nxt = S_RESET_PLL;
            cnt_nxt   = '0;
          end
        end
        S_FAULT: begin
          state_nxt = S_FAULT;
        end
        default: begin
          state_nxt = S_RESET_PLL;
          cnt_nxt   = '0;
        end
      endcase
    end
  end

  // outputs are decoded from the next state so they register alongside it
  always_comb begin
    pll_rst_nxt   = (state_nxt == S_RESET_PLL) || (state_nxt == S_FAULT);
    sys_rst_n_nxt = (state_nxt == S_RUN);
    pll_ready_nxt = (state_nxt == S_RUN);
    fault_nxt     = (state_nxt == S_FAULT);
  end

endmodule

// File: tb/tb_pll_lock_reset_ctrl.sv
// tb/tb_pll_lock_reset_ctrl.sv - directed and random checks of pll_lock_reset_ctrl against a phase model
module tb_pll_lock_reset_ctrl;

  localparam int PRC = 4;
  localparam int TO  = 20;
  localparam int SC  = 8;
  localparam int MR  = 2;
  localparam int CW  = 8;

  localparam int P_RST   = 0;
  localparam int P_WAIT  = 1;
  localparam int P_STAB  = 2;
  localparam int P_RUN   = 3;
  localparam int P_FAULT = 4;

  logic          refclk = 1'b0;
  logic          rst_n = 1'b0;
  logic          pll_locked = 1'b0;
  logic          soft_relock = 1'b0;
  logic          pll_rst, sys_rst_n, pll_ready, fault;
  logic [CW-1:0] lock_lost_cnt, retry_cnt;

  int nassert = 0;
  int nfail = 0;

  int   m_ph, m_t, m_tmo, m_lost, m_retry;
  logic m_h0, m_h1;

  always #10 refclk = ~refclk;

  pll_lock_reset_ctrl #(
    .PLL_RST_CYCLES(PRC),
    .LOCK_TIMEOUT  (TO),
    .STABLE_CYCLES (SC),
    .MAX_RETRY     (MR),
    .CNT_W         (CW)
  ) dut (
    .refclk       (refclk),
    .rst_n        (rst_n),
    .pll_locked   (pll_locked),
    .soft_relock  (soft_relock),
    .pll_rst      (pll_rst),
    .sys_rst_n    (sys_rst_n),
    .pll_ready    (pll_ready),
    .fault        (fault),
    .lock_lost_cnt(lock_lost_cnt),
    .retry_cnt    (retry_cnt)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nassert++;
    assert (obs === exp)
    else begin
      nfail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic void model_reset();
    m_ph = P_RST; m_t = 0; m_tmo = 0; m_lost = 0; m_retry = 0;
    m_h0 = 1'b0; m_h1 = 1'b0;
  endfunction

  function automatic void enter(input int ph);
    m_ph = ph;
    m_t  = 0;
  endfunction

  // One refclk edge: lock seen by the controller is the input from two edges ago.
  function automatic void model_step(input logic l, input logic r);
    logic lk;
    lk   = m_h1;
    m_h1 = m_h0;
    m_h0 = l;
    if (r) begin
      enter(P_RST);
      m_tmo = 0;
    end else if (m_ph == P_RST) begin
      m_t++;
      if (m_t == PRC) enter(P_WAIT);
    end else if (m_ph == P_WAIT) begin
      if (lk) enter(P_STAB);
      else begin
        m_t++;
        if (m_t == TO) begin
          m_retry = (m_retry < 255) ? m_retry + 1 : 255;
          m_tmo++;
          enter((m_tmo == MR) ? P_FAULT : P_RST);
        end
      end
    end else if (m_ph == P_STAB) begin
      if (!lk) enter(P_WAIT);
      else begin
        m_t++;
        if (m_t == SC) begin
          enter(P_RUN);
          m_tmo = 0;
        end
      end
    end else if (m_ph == P_RUN) begin
      if (!lk) begin
        m_lost = (m_lost < 255) ? m_lost + 1 : 255;
        enter(P_RST);
      end
    end
  endfunction

  task automatic check_all();
    chk("pll_rst",       pll_rst,       (m_ph == P_RST || m_ph == P_FAULT) ? 1 : 0);
    chk("sys_rst_n",     sys_rst_n,     (m_ph == P_RUN) ? 1 : 0);
    chk("pll_ready",     pll_ready,     (m_ph == P_RUN) ? 1 : 0);
    chk("fault",         fault,         (m_ph == P_FAULT) ? 1 : 0);
    chk("lock_lost_cnt", lock_lost_cnt, m_lost);
    chk("retry_cnt",     retry_cnt,     m_retry);
  endtask

  task automatic check_reset_vals(input string tag);
    chk({tag, "_pll_rst"},   pll_rst,       1);
    chk({tag, "_sys_rst_n"}, sys_rst_n,     0);
    chk({tag, "_pll_ready"}, pll_ready,     0);
    chk({tag, "_fault"},     fault,         0);
    chk({tag, "_lost"},      lock_lost_cnt, 0);
    chk({tag, "_retry"},     retry_cnt,     0);
  endtask

  task automatic tick(input logic l, input logic r);
    pll_locked  = l;
    soft_relock = r;
    @(posedge refclk);
    if (rst_n) model_step(l, r);
    else model_reset();
    #1;
    soft_relock = 1'b0;
    check_all();
  endtask

  // which: 0 = pll_rst low, 1 = sys_rst_n high, 2 = fault high; n = -1 on timeout
  task automatic run_until(input int which, input logic l, input int maxn, output int n);
    n = -1;
    for (int i = 1; i <= maxn; i++) begin
      tick(l, 1'b0);
      if ((which == 0 && pll_rst === 1'b0) || (which == 1 && sys_rst_n === 1'b1) ||
          (which == 2 && fault === 1'b1)) begin
        n = i;
        break;
      end
    end
  endtask

  initial begin
    int n;
    int run_left;
    logic cur;

    model_reset();
    tick(1'b0, 1'b0);
    tick(1'b0, 1'b0);
    check_reset_vals("por");

    rst_n = 1'b1;
    run_until(0, 1'b0, 50, n);
    chk("rst_window", n, PRC);
    repeat (10) tick(1'b0, 1'b0);
    run_until(1, 1'b1, 50, n);
    chk("lock_to_run", n, 2 + 1 + SC);
    chk("run_ready", pll_ready, 1);
    chk("run_lost0", lock_lost_cnt, 0);
    chk("run_retry0", retry_cnt, 0);

    tick(1'b0, 1'b1);
    run_until(2, 1'b0, 200, n);
    chk("fault_time", n, 2 * (PRC + TO));
    chk("fault_retry", retry_cnt, 2);
    repeat (10) tick(1'b0, 1'b0);
    chk("fault_hold_rst", pll_rst, 1);
    chk("fault_hold_sys", sys_rst_n, 0);
    chk("fault_hold", fault, 1);

    tick(1'b0, 1'b1);
    chk("relock_fault_clr", fault, 0);
    chk("relock_pll_rst", pll_rst, 1);
    repeat (5) tick(1'b0, 1'b0);
    run_until(1, 1'b1, 100, n);
    chk("relock_run", n, 2 + 1 + SC);
    chk("relock_retry", retry_cnt, 2);

    tick(1'b0, 1'b0);
    tick(1'b0, 1'b0);
    chk("loss_t2_sys", sys_rst_n, 1);
    tick(1'b0, 1'b0);
    chk("loss_t3_sys", sys_rst_n, 0);
    chk("loss_t3_rst", pll_rst, 1);
    chk("loss_cnt", lock_lost_cnt, 1);
    run_until(1, 1'b1, 100, n);
    chk("loss_rerun", n, PRC + 1 + SC);

    tick(1'b1, 1'b1);
    repeat (PRC + 1 + 3) tick(1'b1, 1'b0);
    tick(1'b0, 1'b0);
    tick(1'b0, 1'b0);
    run_until(1, 1'b1, 50, n);
    chk("glitch_run", n, 2 + 1 + SC);
    chk("glitch_lost", lock_lost_cnt, 1);
    chk("glitch_retry", retry_cnt, 2);

    run_left = 0;
    cur = 1'b0;
    for (int i = 0; i < 2000; i++) begin
      if (run_left == 0) begin
        cur = ($urandom_range(0, 3) != 0);
        run_left = $urandom_range(1, 30);
      end
      tick(cur, ($urandom_range(0, 63) == 0));
      run_left--;
    end

    for (int k = 0; k < 130; k++) begin
      tick(1'b0, 1'b1);
      run_until(2, 1'b0, 200, n);
      chk("sat_fault_time", n, 2 * (PRC + TO));
    end
    chk("retry_sat", retry_cnt, 255);

    tick(1'b1, 1'b1);
    for (int k = 0; k < 256; k++) begin
      run_until(1, 1'b1, 100, n);
      chk("sat_reach_run", (n > 0) ? 1 : 0, 1);
      repeat (3) tick(1'b0, 1'b0);
    end
    chk("lost_sat", lock_lost_cnt, 255);
    chk("retry_sat_hold", retry_cnt, 255);

    tick(1'b1, 1'b1);
    repeat (PRC + 1 + 2) tick(1'b1, 1'b0);
    chk("mid_stab_ready", pll_ready, 0);
    rst_n = 1'b0;
    #1;
    check_reset_vals("async");
    model_reset();
    tick(1'b1, 1'b0);
    tick(1'b1, 1'b0);
    rst_n = 1'b1;
    run_until(0, 1'b1, 50, n);
    chk("post_rst_window", n, PRC);
    run_until(1, 1'b1, 50, n);
    chk("post_rst_run", n, 1 + SC);

    $display("End of test - %0d assertions evaluated, %0d failures", nassert, nfail);
    $finish;
  end

  initial begin
    #5ms;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

endmodule
